// File: rtl/debug_stream_mux_if.sv
// Bundle of the debug stream mux data-path signals.
// master = node/UART side that drives the inputs, slave = the mux itself.
interface debug_stream_mux_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 7
);
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           out_valid;
  logic                           recv_busy;
  logic [CHANNELS-1:0]            full;
  logic [CHANNELS-1:0]            overflow;
  logic                           clr_overflow;

  modport master (
    output in_valid, in_data, recv_busy, clr_overflow,
    input  out_data, out_valid, full, overflow
  );

  modport slave (
    input  in_valid, in_data, recv_busy, clr_overflow,
    output out_data, out_valid, full, overflow
  );
endinterface

// File: rtl/debug_stream_mux.sv
// Debug stream mux: per-channel character FIFOs feeding a round-robin,
// line-atomic arbiter that serialises the streams onto one UART strobe,
// optionally prefixing every line with "<id>:".

// One channel FIFO with drop-on-full and a sticky overflow flag.
module dsm_chan_fifo #(
  parameter int DATA_WIDTH = 7,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wp, rp, cnt;
  logic                  do_wr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // Both flags come straight off the pointer flops, so they show the count
  // left by the previous cycle; a write is judged against that, before any
  // read in the same cycle.
  assign cnt     = wp - rp;
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_wr   = wr_en & ~full;
  assign rd_data = mem[rp[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
    end
  end

  // Storage, no reset needed: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge res) begin
    if (res)                overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
    else if (clr_ovf)       overflow <= 1'b0;
  end
endmodule

module debug_stream_mux #(
  parameter int CHANNELS    = 4,
  parameter int DATA_WIDTH  = 7,
  parameter int DEPTH       = 16,
  parameter int LINE_ATOMIC = 1,
  parameter int PREFIX_EN   = 1,
  parameter int TIMEOUT     = 255
) (
  input logic clk,
  input logic res,
  debug_stream_mux_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] NL    = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] COLON = DATA_WIDTH'(8'h3A);

  typedef enum logic [1:0] {ARB, SEND_ID, SEND_COLON, SEND_DATA} state_t;

  state_t                              state, state_nxt;
  logic [CW-1:0]                       ptr, ptr_nxt;   // also the current grant
  logic [CHANNELS-1:0]                 line_start, line_start_nxt;
  logic [TW-1:0]                       tcnt, tcnt_nxt;
  logic                                last_vld;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] head;
  logic [CHANNELS-1:0]                 empty, pop, full_w, ovf_w;
  logic                                can_strobe, found, ov;
  logic [CW-1:0]                       sel;
  logic [DATA_WIDTH-1:0]               od;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    dsm_chan_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .res      (res),
      .wr_en    (bus.in_valid[i]),
      .wr_data  (bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en    (pop[i]),
      .clr_ovf  (bus.clr_overflow),
      .rd_data  (head[i]),
      .empty    (empty[i]),
      .full     (full_w[i]),
      .overflow (ovf_w[i])
    );
  end

  assign bus.full     = full_w;
  assign bus.overflow = ovf_w;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;

  // A strobe always needs one quiet cycle before it so the UART can raise busy.
  assign can_strobe = ~bus.recv_busy & ~last_vld;

  // Round-robin scan starting just after the last granted channel.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = ptr;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
  end

  // Next-state and output decode. The strobe is combinational so a granted
  // character leaves the cycle after arbitration.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    line_start_nxt = line_start;
    tcnt_nxt       = tcnt;
    pop            = '0;
    ov             = 1'b0;
    od             = '0;
    case (state)
      ARB: begin
        if (found) begin
          ptr_nxt   = sel;
          state_nxt = (PREFIX_EN != 0 && line_start[sel]) ? SEND_ID : SEND_DATA;
        end
      end
      SEND_ID: begin
        if (can_strobe) begin
          ov        = 1'b1;
          od        = DATA_WIDTH'(48 + int'(ptr));
          state_nxt = SEND_COLON;
        end
      end
      SEND_COLON: begin
        if (can_strobe) begin
          ov        = 1'b1;
          od        = COLON;
          state_nxt = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (!empty[ptr]) begin
          if (can_strobe) begin
            ov                  = 1'b1;
            od                  = head[ptr];
            pop[ptr]            = 1'b1;
            tcnt_nxt            = '0;
            line_start_nxt[ptr] = (head[ptr] == NL);
            if (head[ptr] == NL || LINE_ATOMIC == 0) state_nxt = ARB;
          end
        end else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1)) begin
          // Stalled mid-line too long: give the port away; the rest of this
          // line will carry a fresh prefix when it resumes.
          line_start_nxt[ptr] = 1'b1;
          tcnt_nxt            = '0;
          state_nxt           = ARB;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= ARB;
      ptr        <= CW'(CHANNELS - 1);
      line_start <= '1;
      tcnt       <= '0;
      last_vld   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      line_start <= line_start_nxt;
      tcnt       <= tcnt_nxt;
      last_vld   <= ov;
    end
  end
endmodule

// File: tb/tb_debug_stream_mux.sv
// Bench for debug_stream_mux: two instances (line-atomic with prefixes and
// timeout 8; per-character round robin without prefixes), an expected
// character stream per instance, and literal timing pins.
`timescale 1ns/1ps
module tb_debug_stream_mux;
  localparam int CH = 4, DW = 7, DEP = 16;
  localparam int NL = 10;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_stream_mux_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) ifa ();
  debug_stream_mux_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) ifb ();

  debug_stream_mux #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEP),
    .LINE_ATOMIC(1), .PREFIX_EN(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .res(res), .bus(ifa));

  debug_stream_mux #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DEP),
    .LINE_ATOMIC(0), .PREFIX_EN(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .res(res), .bus(ifb));

  // Expected output streams and observed strobe cycles.
  logic [DW-1:0] exp_a[$], exp_b[$];
  int            cyc_a[$], cyc_b[$];
  logic          a_last = 1'b0, b_last = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process, instance A.
  always @(negedge clk) begin
    if (res) a_last <= 1'b0;
    else begin
      if (ifa.out_valid) begin
        cyc_a.push_back(cyc);
        check("a_strobe_rule", int'({ifa.recv_busy, a_last}), 0);
        check("a_char_expected", int'(exp_a.size() > 0), 1);
        if (exp_a.size() > 0) check("a_char", int'(ifa.out_data), int'(exp_a.pop_front()));
      end
      a_last <= ifa.out_valid;
    end
  end

  // Compare process, instance B.
  always @(negedge clk) begin
    if (res) b_last <= 1'b0;
    else begin
      if (ifb.out_valid) begin
        cyc_b.push_back(cyc);
        check("b_strobe_rule", int'({ifb.recv_busy, b_last}), 0);
        check("b_char_expected", int'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) check("b_char", int'(ifb.out_data), int'(exp_b.pop_front()));
      end
      b_last <= ifb.out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ifa.in_valid = '0;
    ifb.in_valid = '0;
  endtask

  task automatic set_a(input int ch, input int c);
    ifa.in_valid[ch] = 1'b1;
    ifa.in_data[ch*DW +: DW] = DW'(c);
  endtask

  task automatic set_b(input int ch, input int c);
    ifb.in_valid[ch] = 1'b1;
    ifb.in_data[ch*DW +: DW] = DW'(c);
  endtask

  task automatic push_a(input string s);
    for (int i = 0; i < s.len(); i++) exp_a.push_back(DW'(s[i]));
  endtask

  task automatic push_b(input string s);
    for (int i = 0; i < s.len(); i++) exp_b.push_back(DW'(s[i]));
  endtask

  task automatic drain_a(input string name, input int budget);
    int n;
    n = 0;
    while (exp_a.size() != 0 && n < budget) begin step(); n++; end
    check(name, exp_a.size(), 0);
  endtask

  task automatic drain_b(input string name, input int budget);
    int n;
    n = 0;
    while (exp_b.size() != 0 && n < budget) begin step(); n++; end
    check(name, exp_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, found;
    ifa.in_valid = '0; ifa.in_data = '0; ifa.recv_busy = 1'b0; ifa.clr_overflow = 1'b0;
    ifb.in_valid = '0; ifb.in_data = '0; ifb.recv_busy = 1'b0; ifb.clr_overflow = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(ifa.out_valid), 0);
    check("rst_out_data",  int'(ifa.out_data), 0);
    check("rst_full",      int'(ifa.full), 0);
    check("rst_overflow",  int'(ifa.overflow), 0);
    check("rst_b_valid",   int'(ifb.out_valid), 0);
    @(negedge clk) res = 1'b0;
    step();

    // Single line on channel 2, with latency and spacing pins.
    cyc_a.delete();
    push_a("2:A\n");
    t = cyc;
    set_a(2, "A"); step();
    set_a(2, NL);  step();
    drain_a("t1_drain", 100);
    check("t1_strobes", cyc_a.size(), 4);
    if (cyc_a.size() >= 4) begin
      check("t1_first_lat", cyc_a[0] - t, 2);
      check("t1_colon_at",  cyc_a[1] - t, 4);
      check("t1_char_at",   cyc_a[2] - t, 6);
      check("t1_nl_at",     cyc_a[3] - t, 8);
    end
    repeat (4) step();

    // Two simultaneous lines, kept whole.
    push_a("0:ab\n1:cd\n");
    set_a(0, "a"); set_a(1, "c"); step();
    set_a(0, "b"); set_a(1, "d"); step();
    set_a(0, NL);  set_a(1, NL);  step();
    drain_a("t2_drain", 200);
    repeat (4) step();

    // Overflow under a held busy.
    ifa.recv_busy = 1'b1;
    for (int k = 0; k < DEP + 3; k++) begin
      set_a(0, "A" + k);
      if (k == DEP + 2) ifa.clr_overflow = 1'b1;
      @(negedge clk);
      check("t3_full",     int'(ifa.full[0]), int'(k >= DEP));
      check("t3_overflow", int'(ifa.overflow[0]), int'(k >= DEP + 1));
      step();
      ifa.clr_overflow = 1'b0;
    end
    check("t3_ovf_clr_vs_drop", int'(ifa.overflow[0]), 1);
    check("t3_full_held",       int'(ifa.full[0]), 1);
    ifa.clr_overflow = 1'b1; step(); ifa.clr_overflow = 1'b0;
    check("t3_ovf_cleared",     int'(ifa.overflow[0]), 0);
    push_a("0:ABCDEFGHIJKLMNOP");
    ifa.recv_busy = 1'b0;
    drain_a("t3_drain", 200);
    check("t3_full_after", int'(ifa.full[0]), 0);
    repeat (14) step();

    // Mid-line timeout on channel 0 hands the port to channel 1.
    cyc_a.delete();
    push_a("0:x1:y\n");
    t = cyc;
    set_a(0, "x"); step();
    step();
    set_a(1, "y"); step();
    set_a(1, NL);  step();
    drain_a("t4_drain", 200);
    check("t4_strobes", cyc_a.size(), 7);
    if (cyc_a.size() >= 4) begin
      check("t4_x_at",  cyc_a[2] - t, 6);
      check("t4_id1_at", cyc_a[3] - t, 16);
    end
    repeat (4) step();
    push_a("0:z");
    set_a(0, "z"); step();
    drain_a("t4_z_drain", 100);
    repeat (14) step();

    // Round-robin fairness, per-character arbitration.
    cyc_b.delete();
    push_b("ABCDEFGHIJKL");
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      for (int ch = 0; ch < CH; ch++) set_b(ch, "A" + ch + 4*k);
      step();
    end
    drain_b("t5_drain", 200);
    if (cyc_b.size() >= 2) begin
      check("t5_first_lat", cyc_b[0] - t, 2);
      check("t5_spacing",   cyc_b[1] - cyc_b[0], 2);
    end
    repeat (4) step();
    push_b("acbd");
    set_b(0, "a"); set_b(1, "c"); step();
    set_b(0, "b"); set_b(1, "d"); step();
    drain_b("t2b_drain", 100);
    repeat (4) step();

    // Reset mid-line while the strobe is up.
    push_a("3:p");
    set_a(3, "p"); step();
    set_a(3, "q"); step();
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (ifa.out_valid && ifa.out_data == DW'("p")) found = 1;
    end
    check("t6_reached_p", found, 1);
    #1 res = 1'b1;
    #1;
    check("t6_valid_drop", int'(ifa.out_valid), 0);
    check("t6_data_zero",  int'(ifa.out_data), 0);
    check("t6_full_zero",  int'(ifa.full), 0);
    @(negedge clk) res = 1'b0;
    step();
    push_a("3:w");
    set_a(3, "w"); step();
    drain_a("t6_drain", 100);
    repeat (20) step();
    check("end_a_empty", exp_a.size(), 0);
    check("end_b_empty", exp_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
